// File: rtl/smg_scan_module.sv
// Four-digit multiplexed 7-segment scanner: a dwell timer steps a digit FSM, the BCD value is
// latched once per frame, and registered active-low row/column drives are produced with optional leading-zero blanking.
module smg_scan_module #(
   parameter logic [15:0] T1MS = 16'd49_999
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [15:0] NumberSig,
   input  logic        BlankEn,
   output logic [7:0]  Row_Scan_Sig,
   output logic [3:0]  Column_Scan_Sig,
   output logic        FrameDone,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_cnt;
   logic [15:0] r_shadow;
   logic [7:0]  r_row;
   logic [3:0]  r_col;
   logic        r_frame_done;

   logic        w_tick;
   logic        w_boundary;
   logic [3:0]  w_nibble;
   logic [3:0]  w_col;
   logic        w_upper_zero;
   logic [7:0]  w_seg;
   logic [7:0]  w_row;

   // Handshake-free block: NumberSig is sampled only on the frame-boundary tick,
   // BlankEn every cycle; no valid/ready exchange exists on any port.
   assign w_tick     = (r_cnt == T1MS);
   assign w_boundary = w_tick && (r_state == DIG3);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_cnt <= 16'd0;
      end else if (w_tick) begin
         r_cnt <= 16'd0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= DIG0;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next digit plus the nibble, column pattern and "everything above is zero" flag of the current digit.
   always_comb begin
      w_next_state = r_state;
      w_nibble     = r_shadow[3:0];
      w_col        = 4'b1110;
      w_upper_zero = 1'b0;
      case (r_state)
         DIG0: begin
            if (w_tick) w_next_state = DIG1;
         end
         DIG1: begin
            if (w_tick) w_next_state = DIG2;
            w_nibble     = r_shadow[7:4];
            w_col        = 4'b1101;
            w_upper_zero = (r_shadow[15:4] == 12'd0);
         end
         DIG2: begin
            if (w_tick) w_next_state = DIG3;
            w_nibble     = r_shadow[11:8];
            w_col        = 4'b1011;
            w_upper_zero = (r_shadow[15:8] == 8'd0);
         end
         DIG3: begin
            if (w_tick) w_next_state = DIG0;
            w_nibble     = r_shadow[15:12];
            w_col        = 4'b0111;
            w_upper_zero = (r_shadow[15:12] == 4'd0);
         end
         default: begin
            w_next_state = DIG0;
         end
      endcase
   end

   always_comb begin
      w_seg = 8'hBF;
      case (w_nibble)
         4'd0:    w_seg = 8'hC0;
         4'd1:    w_seg = 8'hF9;
         4'd2:    w_seg = 8'hA4;
         4'd3:    w_seg = 8'hB0;
         4'd4:    w_seg = 8'h99;
         4'd5:    w_seg = 8'h92;
         4'd6:    w_seg = 8'h82;
         4'd7:    w_seg = 8'hF8;
         4'd8:    w_seg = 8'h80;
         4'd9:    w_seg = 8'h90;
         default: w_seg = 8'hBF;
      endcase
   end

   // DIG0 never raises w_upper_zero, so the rightmost digit is always lit.
   assign w_row = (BlankEn && w_upper_zero) ? 8'hFF : w_seg;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_shadow <= 16'h0000;
      end else if (w_boundary) begin
         r_shadow <= NumberSig;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_row <= 8'hFF;
         r_col <= 4'b1111;
      end else begin
         r_row <= w_row;
         r_col <= w_col;
      end
   end

   assign Row_Scan_Sig    = r_row;
   assign Column_Scan_Sig = r_col;
   assign FrameDone       = r_frame_done;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_smg_scan_module.sv
// Bench for smg_scan_module with T1MS = 3 (4 cycles per digit, 16 per frame); a frame-level
// model in edge-count arithmetic predicts every registered output.
module tb_smg_scan_module;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [15:0] NumberSig = 16'h0000;
  logic        BlankEn = 1'b0;
  logic [7:0]  Row_Scan_Sig;
  logic [3:0]  Column_Scan_Sig;
  logic        FrameDone;
  logic [1:0]  o_dbg_state;

  int          total = 0;
  int          bad = 0;
  int          k = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [12:0] exp_q[$];
  logic [7:0]  seg_tbl[16];

  smg_scan_module #(.T1MS(16'd3)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .NumberSig      (NumberSig),
    .BlankEn        (BlankEn),
    .Row_Scan_Sig   (Row_Scan_Sig),
    .Column_Scan_Sig(Column_Scan_Sig),
    .FrameDone      (FrameDone),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // Model: k counts edges since reset release; the cycle before edge k shows digit ((k-1)/4)%4,
  // and edge k with k%16==0 is a frame boundary (capture + FrameDone).
  task automatic clk_step();
    int          s;
    logic [15:0] upper;
    logic [7:0]  row;
    logic [3:0]  col;
    logic        fd;
    @(posedge CLK);
    k++;
    s     = ((k - 1) / 4) % 4;
    upper = m_shadow >> (4 * s);
    row   = (BlankEn && s > 0 && upper == 16'd0) ? 8'hFF : seg_tbl[upper[3:0]];
    col   = 4'b1111;
    col[s] = 1'b0;
    fd    = (k % 16 == 0);
    exp_q.push_back({fd, col, row});
    if (fd) m_shadow = NumberSig;
    #1;
  endtask

  task automatic model_reset();
    k = 0;
    m_shadow = 16'h0000;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [12:0] e;
    RSTn = 1'b0;
    #12;
    total++;
    if (Row_Scan_Sig !== 8'hFF) begin
      bad++; $display("FAIL reset_row got=%h exp=FF", Row_Scan_Sig);
    end
    total++;
    if (Column_Scan_Sig !== 4'b1111) begin
      bad++; $display("FAIL reset_col got=%b exp=1111", Column_Scan_Sig);
    end
    total++;
    if (FrameDone !== 1'b0) begin
      bad++; $display("FAIL reset_fd got=%b exp=0", FrameDone);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
    clk_step();
    e = exp_q.pop_front();
    total++;
    if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== {1'b0, 4'b1110, 8'hC0}) begin
      bad++;
      $display("FAIL first_edge got fd=%b col=%b row=%h exp fd=0 col=1110 row=C0",
               FrameDone, Column_Scan_Sig, Row_Scan_Sig);
    end
  endtask

  task automatic test_number_1234();
    logic [12:0] e;
    NumberSig = 16'h1234;
    while (k % 16 != 0 || k == 0) begin
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL n1234_sync k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
    repeat (16) begin
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL n1234_frame k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [12:0] e;
    for (int i = 0; i < 37; i++) begin
      if (i == 5) NumberSig = 16'h5678;
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL mid_change k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
    while (k % 16 != 0) begin
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL mid_change_tail k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
  endtask

  task automatic test_blanking();
    logic [12:0] e;
    BlankEn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      NumberSig = (i < 32) ? 16'h0070 : 16'h0000;
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL blanking k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
  endtask

  task automatic test_hex_dash();
    logic [12:0] e;
    BlankEn   = 1'b0;
    NumberSig = 16'h00A0;
    repeat (32) begin
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL hex_dash k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    logic [15:0] v;
    repeat (192) begin
      if ($urandom_range(0, 5) == 0) begin
        v = 16'($urandom);
        case ($urandom_range(0, 3))
          0: v = v & 16'h00FF;
          1: v = v & 16'h0F0F;
          2: v = 16'h0000;
          default: ;
        endcase
        NumberSig = v;
      end
      if ($urandom_range(0, 9) == 0) BlankEn = ~BlankEn;
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL random k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] e;
    BlankEn   = 1'b0;
    NumberSig = 16'h9876;
    while (k % 16 != 9) begin
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL prereset k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
    #2;
    RSTn = 1'b0;
    #1;
    total++;
    if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== {1'b0, 4'b1111, 8'hFF}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, {1'b0, 4'b1111, 8'hFF});
    end
    @(posedge CLK);
    #1;
    total++;
    if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== {1'b0, 4'b1111, 8'hFF}) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, {1'b0, 4'b1111, 8'hFF});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
    repeat (40) begin
      clk_step();
      e = exp_q.pop_front();
      total++;
      if ({FrameDone, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
        bad++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, {FrameDone, Column_Scan_Sig, Row_Scan_Sig}, e);
      end
    end
  endtask

  initial begin
    seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    test_reset();
    test_number_1234();
    test_mid_frame_change();
    test_blanking();
    test_hex_dash();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
